id_stage_decode: RTL
====================

// Module: id_stage_decode
// PURPOSE
//  Decode stage of the SPARC pipeline. Consumes the IF/ID instruction and PC, then
//  decodes the format (CALL / SETHI / Bicc / arithmetic / load-store).
//  Detects load-use hazards against its own ID/EX register and handles branch annul.
//  Registers the decoded fields into the ID/EX pipeline register that feeds EX.
// PARAMETERS
//  ALU_OP_W  6             width of ALU op field (op3 passthrough)
//  NOP_INSTR 32'h0100_0000 encoding treated as a bubble (sethi 0,%g0)
// PORTS
//  clk          in  1   pipeline clock
//  R            in  1   reset, asynchronous, active-low
//  instr_in     in  32  instruction from IF/ID register
//  pc_in        in  32  PC of instr_in
//  valid_in     in  1   instr_in is a real instruction
//  flush        in  1   EX branch resolution kills the instruction now in ID
//  stall        out 1   comb; 1 = hold PC, nPC and IF/ID (LE low)
//  br_take      out 1   comb; unconditional ba or CALL decoded in ID, not stalled
//  ta           out 32  comb; branch/call target address
//  ex_valid     out 1   ID/EX: slot holds a live instruction
//  ex_pc        out 32  ID/EX: PC
//  ex_rs1/ex_rs2/ex_rd out 5 each  ID/EX: register addresses
//  ex_imm       out 32  ID/EX: sign-extended simm13, or imm22<<10 for SETHI
//  ex_use_imm   out 1   ID/EX: i-bit (operand 2 is ex_imm)
//  ex_alu_op    out ALU_OP_W  ID/EX: op3
//  ex_rf_we, ex_mem_rd, ex_mem_wr, ex_is_call  out 1 each  ID/EX control bits
//  ex_illegal   out 1   ID/EX: illegal opcode (only with ID_ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - Reset (R=0, async): all ID/EX outputs 0, FSM state RUN.
//    stall, br_take and ta are combinational and follow from the reset state.
//  - Latency: 1 cycle from instr_in to ID/EX outputs.
//  - Decode: op=01 CALL, ta=pc_in+{disp30,2'b00}, rd=15, rf_we=1.
//    op=00/op2=100 SETHI. op=00/op2=010 Bicc, ta=pc_in+(sext(disp22)<<2).
//    op=10 arithmetic, rf_we=(rd!=0). op=11 load/store: op3[2]=1 is a store.
//  - Hazard: stall=1 when ex_valid & ex_mem_rd & ex_rd!=0 and ex_rd matches any of:
//    rs1; rs2 with i=0; rd of a decoded store.
//    On stall, ID/EX loads a bubble (ex_valid=0, all control bits 0).
//    A stall lasts exactly 1 cycle, because the bubble clears the match.
//  - FSM RUN/ANNUL: in RUN, a valid non-stalled Bicc with a=1 and cond=1000 (ba,a)
//    or cond=0000 (bn,a) moves to ANNUL.
//    In ANNUL, the next instruction accepted from IF/ID becomes a bubble, then back to RUN.
//    While stalled, the state is held.
//  - br_take=1 for valid, non-stalled ba (cond=1000) or CALL. Conditional Bicc resolves in EX.
//  - flush=1: ID/EX gets a bubble, FSM goes to RUN, and stall is forced to 0.
//    flush takes priority over stall and over ANNUL.
//  - valid_in=0 or instr_in==NOP_INSTR: bubble, no hazard check, no state change.
//  - Reset mid-stall or in ANNUL: the state is lost and the pipeline restarts clean.
// CONFIGURATION
//  ID_ILLEGAL_TRAP_EN defined: op=00 with op2 outside {010,100}, or an undefined op3,
//    sets ex_illegal=1 and ex_valid=1 with all other control bits 0.
//  Not defined: ex_illegal is tied 0, and these encodings decode as a bubble.
// STRUCTURE
//  Shared package sparc_pkg: opcode/op2/op3 localparams, cond codes, NOP_INSTR.
//  One sub-module, id_ex_reg: the ID/EX register with bubble-insert control.
//  Decode and hazard logic stay in this module.
// TESTING
//  1. ld [%g1],%g2 then add %g2,%g3,%g4: 1-cycle stall=1, ex_valid=0, then add issues.
//  2. ba,a disp22=4 at PC 0x40: br_take=1, ta=0x50, delay slot reaches EX with ex_valid=0.
//  3. Load-use stall with flush=1 in the same cycle: stall=0, ex_valid=0, FSM in RUN.
//  4. Assert R low during a stall cycle: all outputs 0 immediately, then normal decode.
//  5. CALL disp30=0x10 at PC 0x100: ta=0x140, ex_rd=15, ex_rf_we=1, ex_is_call=1.
//  6. op=00, op2=000 with the macro defined: ex_illegal=1. Without it: bubble.

Source files
------------

// File: rtl/sparc_pkg.sv
// sparc_pkg: SPARC opcode fields, condition codes, decode FSM states
// and the ID/EX bundle shared by the decode stage and its register.
package sparc_pkg;

    localparam logic [1:0]  OP_FMT2   = 2'b00;
    localparam logic [1:0]  OP_CALL   = 2'b01;
    localparam logic [1:0]  OP_ARITH  = 2'b10;
    localparam logic [1:0]  OP_MEM    = 2'b11;

    localparam logic [2:0]  OP2_BICC  = 3'b010;
    localparam logic [2:0]  OP2_SETHI = 3'b100;

    localparam logic [3:0]  COND_BN   = 4'b0000;
    localparam logic [3:0]  COND_BA   = 4'b1000;

    localparam logic [4:0]  REG_O7    = 5'd15;
    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

    typedef enum logic {
        ST_RUN,
        ST_ANNUL
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic [5:0]  alu_op;
        logic        rf_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        is_call;
        logic        illegal;
    } id_ex_t;

    // op3 values implemented for op=10 (ALU, shifts, jmpl, save/restore)
    function automatic logic arith_op3_ok(input logic [5:0] op3);
        case (op3) inside
            [6'h00:6'h08], [6'h0A:6'h18], [6'h1A:6'h1F],
            6'h25, 6'h26, 6'h27, 6'h38, 6'h3C, 6'h3D:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // op3 values implemented for op=11 (ld/st family)
    function automatic logic mem_op3_ok(input logic [5:0] op3);
        case (op3) inside
            [6'h00:6'h07], 6'h09, 6'h0A:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register; a bubble request clears every
// field so EX sees no valid instruction and no control bits.
module id_ex_reg
    import sparc_pkg::*;
(
    input  logic   clk,
    input  logic   R,
    input  logic   i_bubble,
    input  id_ex_t i_dec,
    output id_ex_t o_q
);

    id_ex_t r_q;

    // Load the decoded bundle or a bubble every cycle
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_q <= '0;
        end else if (i_bubble) begin
            r_q <= '0;
        end else begin
            r_q <= i_dec;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_stage_decode.sv
// id_stage_decode: SPARC decode with load-use stall and ba,a/bn,a annul.
// Define ID_ILLEGAL_TRAP_EN to issue undefined encodings with ex_illegal.
module id_stage_decode
    import sparc_pkg::*;
#(
    parameter int          ALU_OP_W  = 6,
    parameter logic [31:0] NOP_INSTR = SPARC_NOP
) (
    input  logic                clk,
    input  logic                R,
    input  logic [31:0]         instr_in,
    input  logic [31:0]         pc_in,
    input  logic                valid_in,
    input  logic                flush,
    output logic                stall,
    output logic                br_take,
    output logic [31:0]         ta,
    output logic                ex_valid,
    output logic [31:0]         ex_pc,
    output logic [4:0]          ex_rs1,
    output logic [4:0]          ex_rs2,
    output logic [4:0]          ex_rd,
    output logic [31:0]         ex_imm,
    output logic                ex_use_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_rf_we,
    output logic                ex_mem_rd,
    output logic                ex_mem_wr,
    output logic                ex_is_call,
    output logic                ex_illegal
);

    logic [1:0] w_op;
    logic [2:0] w_op2;
    logic [3:0] w_cond;
    logic [5:0] w_op3;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic       w_a, w_i;

    assign w_op   = instr_in[31:30];
    assign w_rd   = instr_in[29:25];
    assign w_a    = instr_in[29];
    assign w_cond = instr_in[28:25];
    assign w_op2  = instr_in[24:22];
    assign w_op3  = instr_in[24:19];
    assign w_rs1  = instr_in[18:14];
    assign w_i    = instr_in[13];
    assign w_rs2  = instr_in[4:0];

    logic w_live, w_call, w_sethi, w_bicc, w_arith, w_mem;
    logic w_arith_ok, w_mem_ok, w_legal, w_store;
    logic w_ld_hit, w_match, w_bubble, w_annul_br;

    state_t r_state, w_state_nx;
    id_ex_t w_dec, w_q;

    assign w_live     = valid_in && (instr_in != NOP_INSTR);
    assign w_call     = (w_op == OP_CALL);
    assign w_sethi    = (w_op == OP_FMT2) && (w_op2 == OP2_SETHI);
    assign w_bicc     = (w_op == OP_FMT2) && (w_op2 == OP2_BICC);
    assign w_arith    = (w_op == OP_ARITH);
    assign w_mem      = (w_op == OP_MEM);
    assign w_arith_ok = w_arith && arith_op3_ok(w_op3);
    assign w_mem_ok   = w_mem && mem_op3_ok(w_op3);
    assign w_legal    = w_call || w_sethi || w_bicc
                     || w_arith_ok || w_mem_ok;
    assign w_store    = w_mem && w_op3[2];
    assign w_annul_br = w_bicc && w_a
                     && (w_cond == COND_BA || w_cond == COND_BN);

    // Format decode into the ID/EX bundle
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = pc_in;
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        w_dec.rd      = w_call ? REG_O7 : w_rd;
        w_dec.imm     = w_sethi ? {instr_in[21:0], 10'b0}
                                : {{19{instr_in[12]}}, instr_in[12:0]};
        w_dec.use_imm = w_i;
        w_dec.alu_op  = w_op3;
        unique case (1'b1)
            w_call: begin
                w_dec.valid   = 1'b1;
                w_dec.rf_we   = 1'b1;
                w_dec.is_call = 1'b1;
            end
            w_sethi: begin
                w_dec.valid = 1'b1;
                w_dec.rf_we = (w_rd != 5'd0);
            end
            w_bicc: begin
                w_dec.valid = 1'b1;
            end
            w_arith_ok: begin
                w_dec.valid = 1'b1;
                w_dec.rf_we = (w_rd != 5'd0);
            end
            w_mem_ok: begin
                w_dec.valid  = 1'b1;
                w_dec.mem_wr = w_store;
                w_dec.mem_rd = !w_store;
                w_dec.rf_we  = !w_store && (w_rd != 5'd0);
            end
`ifdef ID_ILLEGAL_TRAP_EN
            default: begin
                w_dec.valid   = 1'b1;
                w_dec.illegal = 1'b1;
            end
`else
            default: begin
                w_dec.valid = 1'b0;
            end
`endif
        endcase
    end

    // Load-use check: rs1/rs2 only exist in op=10/11 formats
    assign w_ld_hit = w_q.valid && w_q.mem_rd && (w_q.rd != 5'd0);
    assign w_match  = ((w_arith || w_mem)
                       && (w_rs1 == w_q.rd
                           || (!w_i && w_rs2 == w_q.rd)))
                   || (w_store && w_rd == w_q.rd);
    assign stall    = w_live && w_legal && w_ld_hit
                   && w_match && !flush;

    assign w_bubble = flush || !w_live || stall
                   || !w_dec.valid || (r_state == ST_ANNUL);

    assign br_take  = w_live && !stall && !flush
                   && (r_state == ST_RUN)
                   && (w_call || (w_bicc && w_cond == COND_BA));

    assign ta = w_call ? pc_in + {instr_in[29:0], 2'b00}
                       : pc_in + {{8{instr_in[21]}},
                                  instr_in[21:0], 2'b00};

    // Annul state register
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Annul next-state: only accepted real instructions advance it
    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = ST_RUN;
        end else if (w_live && !stall) begin
            if (r_state == ST_ANNUL) begin
                w_state_nx = ST_RUN;
            end else if (w_annul_br) begin
                w_state_nx = ST_ANNUL;
            end
        end
    end

    id_ex_reg u_id_ex_reg (
        .clk      (clk),
        .R        (R),
        .i_bubble (w_bubble),
        .i_dec    (w_dec),
        .o_q      (w_q)
    );

    assign ex_valid   = w_q.valid;
    assign ex_pc      = w_q.pc;
    assign ex_rs1     = w_q.rs1;
    assign ex_rs2     = w_q.rs2;
    assign ex_rd      = w_q.rd;
    assign ex_imm     = w_q.imm;
    assign ex_use_imm = w_q.use_imm;
    assign ex_alu_op  = ALU_OP_W'(w_q.alu_op);
    assign ex_rf_we   = w_q.rf_we;
    assign ex_mem_rd  = w_q.mem_rd;
    assign ex_mem_wr  = w_q.mem_wr;
    assign ex_is_call = w_q.is_call;
    assign ex_illegal = w_q.illegal;

endmodule
